// File: rtl/freq_div_sequencer.sv
// freq_div_sequencer: arbitrates divide-value requests from several clients and
// reprograms one frequency divider safely (stop, load, restart, ack).
// All divider-facing outputs are registered and follow the state by one cycle.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a request; arbitration happens here
//   S_DRAIN | divider held disabled for DRAIN_CYCLES before the load
//   S_LOAD  | divider disabled, ConfigDiv pulsed with the latched value
//   S_START | divider re-enabled with the new value
//   S_ACK   | winner acknowledged, round-robin pointer advanced
module freq_div_sequencer #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 32,
  parameter int DRAIN_CYCLES = 2,
  localparam int IW          = $clog2(NREQ)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ*WIDTH-1:0]  ReqDiv,
  input  logic                   Stop,
  output logic [NREQ-1:0]        Ack,
  output logic [WIDTH-1:0]       DivDin,
  output logic                   DivConfig,
  output logic                   DivEnable,
  output logic [WIDTH-1:0]       CurDiv,
  output logic [IW-1:0]          Owner,
  output logic                   Busy
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     winner;
  logic [WIDTH-1:0]  latched;
  logic [CW-1:0]     drain_cnt;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [WIDTH-1:0]  pick_div;
  logic              fast;
  logic              grant;

  logic [NREQ-1:0]   ack_d;
  logic [WIDTH-1:0]  din_d;
  logic              config_d;
  logic              enable_d;
  logic [WIDTH-1:0]  cur_d;
  logic [IW-1:0]     owner_d;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (Req[(int'(ptr) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign pick_div = ReqDiv[int'(pick_idx)*WIDTH +: WIDTH];
  // Same value already running: skip the reprogram entirely.
  assign fast     = DivEnable && (pick_div == CurDiv);
  assign grant    = (state == S_IDLE) && !Stop && pick_vld;
  assign Busy     = (state != S_IDLE);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; Stop aborts any sequence that has not reached ACK.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant) begin
          if (fast)                   state_nxt = S_ACK;
          else if (DRAIN_CYCLES == 0) state_nxt = S_LOAD;
          else                        state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (Stop)                state_nxt = S_IDLE;
        else if (drain_cnt == 0) state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = Stop ? S_IDLE : S_START;
      S_START: state_nxt = Stop ? S_IDLE : S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, drain down-counter and round-robin pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      winner    <= '0;
      latched   <= '0;
      drain_cnt <= '0;
      ptr       <= '0;
    end else begin
      if (grant) begin
        winner    <= pick_idx;
        latched   <= pick_div;
        drain_cnt <= DRAIN_LOAD;
      end else if (state == S_DRAIN && drain_cnt != 0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
      if (state == S_ACK) ptr <= IW'((int'(winner) + 1) % NREQ);
    end
  end

  // Output decode; Stop overrides the divider controls in every state.
  always_comb begin
    ack_d    = '0;
    din_d    = DivDin;
    config_d = 1'b0;
    enable_d = DivEnable;
    cur_d    = CurDiv;
    owner_d  = Owner;
    case (state)
      S_DRAIN: enable_d = 1'b0;
      S_LOAD: begin
        enable_d = 1'b0;
        config_d = 1'b1;
        din_d    = latched;
      end
      S_START: begin
        enable_d = 1'b1;
        cur_d    = latched;
      end
      S_ACK: begin
        ack_d[winner] = 1'b1;
        owner_d       = winner;
      end
      default: ;
    endcase
    if (Stop) begin
      enable_d = 1'b0;
      config_d = 1'b0;
      din_d    = DivDin;
    end
  end

  // Registered outputs so the divider sees glitch-free controls.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ack       <= '0;
      DivDin    <= '0;
      DivConfig <= 1'b0;
      DivEnable <= 1'b0;
      CurDiv    <= '0;
      Owner     <= '0;
    end else begin
      Ack       <= ack_d;
      DivDin    <= din_d;
      DivConfig <= config_d;
      DivEnable <= enable_d;
      CurDiv    <= cur_d;
      Owner     <= owner_d;
    end
  end

endmodule

// File: tb/tb_freq_div_sequencer.sv
// Bench for freq_div_sequencer: directed scenarios plus randomized requests,
// checked against a transaction-level round-robin model.
module tb_freq_div_sequencer;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DRAIN = 2;

  logic            Clk;
  logic            Reset;
  logic [N-1:0]    req;
  logic [W-1:0]    div_val [N];
  logic [N*W-1:0]  ReqDiv;
  logic            Stop;
  logic [N-1:0]    Ack;
  logic [W-1:0]    DivDin, CurDiv;
  logic            DivConfig, DivEnable, Busy;
  logic [1:0]      Owner;

  logic [N-1:0]    req0;
  logic [N*W-1:0]  ReqDiv0;
  logic            Stop0;
  logic [N-1:0]    Ack0;
  logic [W-1:0]    DivDin0, CurDiv0;
  logic            DivConfig0, DivEnable0, Busy0;
  logic [1:0]      Owner0;

  int n_chk = 0;
  int n_err = 0;

  int          m_ptr;
  logic [W-1:0] m_cur;
  bit          m_en;

  logic [W-1:0] vals [5] = '{32'd0, 32'd3, 32'd5, 32'd7, 32'd9};

  assign ReqDiv = {div_val[3], div_val[2], div_val[1], div_val[0]};

  freq_div_sequencer #(.NREQ(N), .WIDTH(W), .DRAIN_CYCLES(DRAIN)) dut (
    .Clk(Clk), .Reset(Reset), .Req(req), .ReqDiv(ReqDiv), .Stop(Stop),
    .Ack(Ack), .DivDin(DivDin), .DivConfig(DivConfig), .DivEnable(DivEnable),
    .CurDiv(CurDiv), .Owner(Owner), .Busy(Busy));

  freq_div_sequencer #(.NREQ(N), .WIDTH(W), .DRAIN_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(req0), .ReqDiv(ReqDiv0), .Stop(Stop0),
    .Ack(Ack0), .DivDin(DivDin0), .DivConfig(DivConfig0), .DivEnable(DivEnable0),
    .CurDiv(CurDiv0), .Owner(Owner0), .Busy(Busy0));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first pending client at or after the pointer.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    m_cur = '0;
    m_en  = 1'b0;
  endfunction

  // One served request on the main DUT. Called at a negedge with the DUT idle;
  // the next posedge is the grant edge. Returns at the negedge after Ack.
  task automatic run_txn(input bit hold);
    int           w, lat, cyc, cfg_cnt, cfg_cyc, bad, en_low;
    logic [W-1:0] v, din;
    logic [N-1:0] ack_seen;
    bit           fast;
    w    = rr_pick(req, m_ptr);
    if (w < 0) w = 0;
    v    = div_val[w];
    fast = m_en && (v == m_cur);
    lat  = fast ? 1 : DRAIN + 3;
    cyc = 0; cfg_cnt = 0; cfg_cyc = 0; bad = 0; en_low = 0; din = '0; ack_seen = '0;
    @(posedge Clk);
    @(negedge Clk);
    check("busy_after_grant", Busy, 1);
    while (cyc < 20 && ack_seen == 0) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (DivConfig) begin
        cfg_cnt++;
        cfg_cyc = cyc;
        din     = DivDin;
      end
      if (DivConfig && DivEnable) bad++;
      if (!DivEnable && ack_seen == 0 && Ack == 0) en_low++;
      if (Ack != 0) ack_seen = Ack;
    end
    check("ack_onehot", ack_seen, 64'(1) << w);
    check("ack_latency", cyc, lat);
    check("cfg_pulses", cfg_cnt, fast ? 0 : 1);
    check("cfg_while_en", bad, 0);
    if (fast) check("fast_en_stays", en_low, 0);
    else begin
      check("cfg_cycle", cfg_cyc, DRAIN + 1);
      check("cfg_din", din, v);
    end
    check("curdiv", CurDiv, v);
    check("enable_after", DivEnable, 1);
    check("owner", Owner, w);
    m_ptr = (w + 1) % N;
    m_cur = v;
    m_en  = 1'b1;
    if (!hold) req[w] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ackc, cfgc;
    logic [W-1:0] din0;
    logic [N-1:0] acc_ack;
    logic acc_cfg;

    Reset = 1'b1; Stop = 1'b0; req = '0; Stop0 = 1'b0; req0 = '0; ReqDiv0 = '0;
    for (int i = 0; i < N; i++) div_val[i] = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_data", {DivDin, CurDiv}, 0);
    check("rst_ctrl", {Ack, DivConfig, DivEnable, Owner, Busy}, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Single client, value 5, full reprogram path.
    req = 4'b0001; div_val[0] = 32'd5;
    run_txn(1'b0);

    // Same value from another client takes the fast path.
    req = 4'b0100; div_val[2] = 32'd5;
    run_txn(1'b0);

    // All clients held high with distinct values: strict rotation.
    div_val[0] = 32'd3; div_val[1] = 32'd7; div_val[2] = 32'd9; div_val[3] = 32'd11;
    req = 4'b1111;
    for (int t = 0; t < 6; t++) run_txn(1'b1);
    req = '0;

    // Stop raised while loading 9: abort, then re-serve the same client.
    req = 4'b0010; div_val[1] = 32'd9;
    if (m_cur == 32'd9) div_val[1] = 32'd13;
    @(posedge Clk); @(posedge Clk); @(posedge Clk);
    @(negedge Clk);
    Stop = 1'b1;
    acc_ack = '0; acc_cfg = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      acc_ack |= Ack;
      acc_cfg |= DivConfig;
    end
    check("stop_no_ack", acc_ack, 0);
    check("stop_no_cfg", acc_cfg, 0);
    check("stop_en_low", DivEnable, 0);
    check("stop_curdiv", CurDiv, m_cur);
    check("stop_idle", Busy, 0);
    m_en = 1'b0;
    Stop = 1'b0;
    run_txn(1'b0);

    // Randomized request traffic, each client holding Req until its Ack.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          div_val[i] = vals[$urandom_range(0, 4)];
        end
      end
      if (req == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        req[i] = 1'b1;
        div_val[i] = vals[$urandom_range(0, 4)];
      end
      run_txn(1'b0);
    end
    for (int t = 0; t < N && req != 0; t++) run_txn(1'b0);

    // Reset while draining: everything clears, arbitration restarts at client 0.
    req = 4'b1100; div_val[2] = 32'd21; div_val[3] = 32'd22;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("rst_mid_data", {DivDin, CurDiv}, 0);
    check("rst_mid_ctrl", {Ack, DivConfig, DivEnable, Owner, Busy}, 0);
    #1;
    Reset = 1'b0;
    model_reset();
    run_txn(1'b0);
    run_txn(1'b0);

    // Zero drain, zero divide value on the second instance.
    req0 = 4'b0001;
    ackc = 0; cfgc = 0; din0 = 32'hFFFF_FFFF; acc_ack = '0;
    @(posedge Clk);
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (DivConfig0 && cfgc == 0) begin
        cfgc = c;
        din0 = DivDin0;
      end
      if (Ack0 != 0 && ackc == 0) begin
        ackc = c;
        acc_ack = Ack0;
        req0 = '0;
      end
    end
    check("d0_cfg_cycle", cfgc, 1);
    check("d0_din", din0, 0);
    check("d0_ack_cycle", ackc, 3);
    check("d0_ack", acc_ack, 4'b0001);
    check("d0_curdiv", CurDiv0, 0);
    check("d0_enable", DivEnable0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
